multi_com_tracker: RTL and testbench
====================================

# multi_com_tracker

Parametrised successor to the single-channel centre-of-mass stage. It accumulates coordinate sums and pixel counts for `N_CH` independent threshold masks over a camera frame. On each frame boundary it snapshots those totals, then computes every channel's centroid with one shared serial divider. It sits between the threshold/mask stage and `compare` on the 65 MHz pipeline, and adds per-channel presence detection with hold-last behaviour.

## Interface
- `N_CH`, 2, number of mask channels
- `H_W`, 11, x coordinate width
- `V_W`, 10, y coordinate width
- `CNT_W`, 17, pixel-count width (320*240 fits)
- `MIN_COUNT`, 16, minimum pixel count for a channel to be present
- `clk_in`  in  1  system clock (65 MHz)
- `rst_in`  in  1  asynchronous, active-low reset
- `x_in`  in  H_W  pixel column, aligned with `mask_in`
- `y_in`  in  V_W  pixel row, aligned with `mask_in`
- `valid_in`  in  1  pixel strobe
- `mask_in`  in  N_CH  per-channel threshold result; sampled only when `valid_in` is high
- `tabulate_in`  in  1  frame-boundary pulse
- `hold_in`  in  1  1: absent channels keep their last centroid; 0: absent channels output 0
- `x_com_out`  out  N_CH*H_W  packed centroid x; channel 0 in the LSBs
- `y_com_out`  out  N_CH*V_W  packed centroid y
- `present_out`  out  N_CH  channel count >= MIN_COUNT in the last frame
- `valid_com_out`  out  1  one-cycle pulse when all outputs have been updated
- `busy_out`  out  1  high while results are being computed
- `overrun_out`  out  1  sticky; set when `tabulate_in` arrives while busy, cleared only by reset

## Operation
- Accumulators, per channel c:
  - `sx[c]` has width `DIV_W = H_W+CNT_W`; `sy[c]` uses the same width with y zero-extended; `cnt[c]` has width CNT_W.
  - On `valid_in && mask_in[c]`: `sx += x_in`, `sy += y_in`, `cnt += 1`.
  - Saturation: when `cnt` reaches all-ones, that channel stops accumulating until the next snapshot.
- Accumulation never stops, including while the block is busy.
- Frame boundary (`tabulate_in` high while state is IDLE):
  - Copy all accumulators to shadow registers and clear them in the same cycle.
  - A valid pixel on the `tabulate_in` cycle is counted in the new frame.
- `tabulate_in` while busy: no snapshot is taken, the frames merge, and `overrun_out` is set.
- State machine:
  - IDLE: on `tabulate_in`, go to SNAP.
  - SNAP: 1 cycle; load the divider with channel 0's x numerator; go to DIV.
  - DIV: division order is ch0 x, ch0 y, ch1 x, …; each division takes exactly DIV_W cycles. After the last division, go to DONE.
  - DONE: 1 cycle; update outputs, pulse `valid_com_out`; go to IDLE.
- Divisions always run for every channel, so latency is fixed. The quotient is truncated, and its low H_W (or V_W) bits are kept.
- A divisor of 0 yields all-ones. That result is discarded because the channel is absent (MIN_COUNT >= 1).
- Output update in DONE, per channel:
  - If present: load the quotient and set `present_out[c]=1`.
  - Otherwise: `present_out[c]=0`; the centroid is held if `hold_in`=1, or zeroed if `hold_in`=0.
  - `hold_in` is sampled in DONE.
- Reset (asynchronous, any time including mid-division):
  - All accumulators, shadows and outputs go to 0, `overrun_out`=0, state = IDLE.
  - The division in progress is abandoned, and no `valid_com_out` is issued for it.

## Timing
- Latency from `tabulate_in` to the `valid_com_out` pulse: `1 + 2*N_CH*DIV_W + 1` cycles. With default parameters this is 114 cycles.
- `busy_out` is high from the cycle after `tabulate_in` through the DONE cycle inclusive.
- Outputs change only in DONE, so they are stable for an entire frame.
- Pixel input has a throughput of 1 per cycle with no backpressure. Accumulator update latency is 1 cycle.

## Structure
- Package `com_pkg`:
  - State enum `com_state_t` (IDLE, SNAP, DIV, DONE).
  - Default width constants.
  - `DIV_W` derivation function.
- Sub-module `serial_divider`:
  - Restoring divider, 1 quotient bit per cycle.
  - Ports: `start`, `dividend[DIV_W]`, `divisor[CNT_W]`, `quotient`, `done`.
  - Parametrised on `DIV_W`/`CNT_W`; same clock and reset as the parent.
- The top module owns the accumulators, shadows, channel/axis sequencer and output registers.

## Test plan
- Single present channel:
  - Stimulus: ch0 mask over the 4x4 block x=100..103, y=50..53, then `tabulate_in`.
  - Response: after 114 cycles, `valid_com_out`=1, ch0 = (101,51), `present_out`=2'b01.
- Two channels:
  - Stimulus: ch0 block at (10..13, 20..23), ch1 block at (300..303, 200..203).
  - Response: ch0 = (11,21), ch1 = (301,201), `present_out`=2'b11.
- Below MIN_COUNT:
  - Stimulus: a first frame giving ch0 = (101,51); a second frame with 5 ch0 pixels.
  - Response: with `hold_in`=1, output stays (101,51) and `present_out[0]`=0; with `hold_in`=0, output is (0,0).
- Overrun:
  - Stimulus: `tabulate_in` 40 cycles after a prior `tabulate_in`.
  - Response: `overrun_out`=1; exactly one `valid_com_out`; pixels from both frames merge into the next result.
- Reset mid-division:
  - Stimulus: assert `rst_in`=0 at cycle 60 of DIV.
  - Response: all outputs are 0 immediately, with no `valid_com_out`. The next frame computes correctly from clean accumulators.
- Boundary pixel:
  - Stimulus: a valid ch0 pixel at (7,7) coincident with `tabulate_in`.
  - Response: it is excluded from the current result and included in the next frame's count.

Source files
------------

// File: rtl/com_pkg.sv
// rtl/com_pkg.sv - shared state type, default widths and divider width helper
package com_pkg;
  typedef enum logic [1:0] {IDLE, SNAP, DIV, DONE} com_state_t;

  localparam int DEF_N_CH      = 2;
  localparam int DEF_H_W       = 11;
  localparam int DEF_V_W       = 10;
  localparam int DEF_CNT_W     = 17;
  localparam int DEF_MIN_COUNT = 16;

  // Dividend must hold a full frame of maximum coordinates.
  function automatic int div_width(input int h_w, input int cnt_w);
    return h_w + cnt_w;
  endfunction
endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - restoring divider, one quotient bit per cycle
// The start cycle already retires the first bit, so a division takes DIV_W cycles.
module serial_divider #(
  parameter int DIV_W = 28,
  parameter int CNT_W = 17
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);
  localparam int C_W = $clog2(DIV_W + 1);

  logic [CNT_W-1:0] rem, dsr, rem_src, dsr_src, rem_nxt;
  logic [DIV_W-1:0] quo_src, quo_nxt;
  logic [CNT_W:0]   trial, diff;
  logic [C_W-1:0]   left;
  logic             running;

  always_comb begin
    rem_src = start ? '0 : rem;
    quo_src = start ? dividend : quotient;
    dsr_src = start ? divisor : dsr;
    trial   = {rem_src, quo_src[DIV_W-1]};
    diff    = trial - {1'b0, dsr_src};
    if (trial >= {1'b0, dsr_src}) begin
      rem_nxt = diff[CNT_W-1:0];
      quo_nxt = {quo_src[DIV_W-2:0], 1'b1};
    end else begin
      rem_nxt = trial[CNT_W-1:0];
      quo_nxt = {quo_src[DIV_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
      left     <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= rem_nxt;
        quotient <= quo_nxt;
        dsr      <= divisor;
        left     <= C_W'(DIV_W - 1);
        running  <= (DIV_W > 1);
        done     <= (DIV_W == 1);
      end else if (running) begin
        rem      <= rem_nxt;
        quotient <= quo_nxt;
        left     <= left - 1'b1;
        if (left == C_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/multi_com_tracker.sv
// rtl/multi_com_tracker.sv - per-channel centroid tracker sharing one serial divider
// Accumulators always run; shadows feed a fixed-latency divide sequence each frame.
module multi_com_tracker
  import com_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int H_W       = DEF_H_W,
  parameter int V_W       = DEF_V_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MIN_COUNT = DEF_MIN_COUNT
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [H_W-1:0]      x_in,
  input  logic [V_W-1:0]      y_in,
  input  logic                valid_in,
  input  logic [N_CH-1:0]     mask_in,
  input  logic                tabulate_in,
  input  logic                hold_in,
  output logic [N_CH*H_W-1:0] x_com_out,
  output logic [N_CH*V_W-1:0] y_com_out,
  output logic [N_CH-1:0]     present_out,
  output logic                valid_com_out,
  output logic                busy_out,
  output logic                overrun_out
);
  localparam int DIV_W = div_width(H_W, CNT_W);
  localparam int N_DIV = 2 * N_CH;
  localparam int IDX_W = $clog2(N_DIV);

  com_state_t       state;
  logic [DIV_W-1:0] sx [N_CH], sy [N_CH], shx [N_CH], shy [N_CH];
  logic [CNT_W-1:0] cnt [N_CH], shc [N_CH];
  logic [H_W-1:0]   res_x [N_CH];
  logic [V_W-1:0]   res_y [N_CH], y_fin [N_CH];
  logic [IDX_W-1:0] idx, sel;
  logic [IDX_W-2:0] ch_sel;
  logic [N_CH-1:0]  hit;
  logic [DIV_W-1:0] dividend, quotient;
  logic [CNT_W-1:0] divisor;
  logic             snap, last_div, div_start, div_done, unused_bits;

  assign hit         = valid_in ? mask_in : '0;
  assign snap        = tabulate_in && (state == IDLE);
  assign last_div    = (idx == IDX_W'(N_DIV - 1));
  assign div_start   = (state == SNAP) || (state == DIV && div_done && !last_div);
  assign sel         = (state == SNAP) ? '0 : idx + 1'b1;
  assign ch_sel      = sel[IDX_W-1:1];
  assign dividend    = sel[0] ? shy[ch_sel] : shx[ch_sel];
  assign divisor     = shc[ch_sel];
  assign busy_out    = (state != IDLE);
  assign unused_bits = ^quotient[DIV_W-1:H_W];

  // The final division (last channel, y) is still in the divider when outputs load.
  always_comb begin
    for (int c = 0; c < N_CH; c++) y_fin[c] = res_y[c];
    y_fin[N_CH-1] = quotient[V_W-1:0];
  end

  serial_divider #(.DIV_W(DIV_W), .CNT_W(CNT_W)) u_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int c = 0; c < N_CH; c++) begin
        sx[c]  <= '0;
        sy[c]  <= '0;
        cnt[c] <= '0;
        shx[c] <= '0;
        shy[c] <= '0;
        shc[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (snap) begin
          shx[c] <= sx[c];
          shy[c] <= sy[c];
          shc[c] <= cnt[c];
          sx[c]  <= hit[c] ? DIV_W'(x_in) : '0;
          sy[c]  <= hit[c] ? DIV_W'(y_in) : '0;
          cnt[c] <= hit[c] ? CNT_W'(1) : '0;
        end else if (hit[c] && cnt[c] != '1) begin
          sx[c]  <= sx[c] + DIV_W'(x_in);
          sy[c]  <= sy[c] + DIV_W'(y_in);
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      idx           <= '0;
      valid_com_out <= 1'b0;
      overrun_out   <= 1'b0;
      present_out   <= '0;
      x_com_out     <= '0;
      y_com_out     <= '0;
      for (int c = 0; c < N_CH; c++) begin
        res_x[c] <= '0;
        res_y[c] <= '0;
      end
    end else begin
      valid_com_out <= 1'b0;
      if (tabulate_in && state != IDLE) overrun_out <= 1'b1;
      case (state)
        IDLE: if (tabulate_in) begin
          state <= SNAP;
          idx   <= '0;
        end
        SNAP: state <= DIV;
        DIV: if (div_done) begin
          if (idx[0]) res_y[idx[IDX_W-1:1]] <= quotient[V_W-1:0];
          else        res_x[idx[IDX_W-1:1]] <= quotient[H_W-1:0];
          if (last_div) begin
            state         <= DONE;
            valid_com_out <= 1'b1;
            for (int c = 0; c < N_CH; c++) begin
              if (shc[c] >= CNT_W'(MIN_COUNT)) begin
                x_com_out[c*H_W +: H_W] <= res_x[c];
                y_com_out[c*V_W +: V_W] <= y_fin[c];
                present_out[c]          <= 1'b1;
              end else begin
                present_out[c] <= 1'b0;
                if (!hold_in) begin
                  x_com_out[c*H_W +: H_W] <= '0;
                  y_com_out[c*V_W +: V_W] <= '0;
                end
              end
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_com_tracker.sv
// tb/tb_multi_com_tracker.sv - self-checking bench for multi_com_tracker with a sum/count reference model
module tb_multi_com_tracker;
  localparam int N_CH      = 2;
  localparam int H_W       = 11;
  localparam int V_W       = 10;
  localparam int CNT_W     = 17;
  localparam int MIN_COUNT = 16;
  localparam int LATENCY   = 114;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [H_W-1:0]      x_in;
  logic [V_W-1:0]      y_in;
  logic                valid_in;
  logic [N_CH-1:0]     mask_in;
  logic                tabulate_in;
  logic                hold_in;
  logic [N_CH*H_W-1:0] x_com;
  logic [N_CH*V_W-1:0] y_com;
  logic [N_CH-1:0]     present;
  logic                valid_com;
  logic                busy;
  logic                overrun;

  int passed = 0;
  int total  = 0;

  longint          msx [N_CH], msy [N_CH], mn [N_CH], ex [N_CH], ey [N_CH];
  logic [N_CH-1:0] ep;

  always #5 clk = ~clk;

  multi_com_tracker #(
    .N_CH(N_CH), .H_W(H_W), .V_W(V_W), .CNT_W(CNT_W), .MIN_COUNT(MIN_COUNT)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .x_in          (x_in),
    .y_in          (y_in),
    .valid_in      (valid_in),
    .mask_in       (mask_in),
    .tabulate_in   (tabulate_in),
    .hold_in       (hold_in),
    .x_com_out     (x_com),
    .y_com_out     (y_com),
    .present_out   (present),
    .valid_com_out (valid_com),
    .busy_out      (busy),
    .overrun_out   (overrun)
  );

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      msx[c] = 0; msy[c] = 0; mn[c] = 0; ex[c] = 0; ey[c] = 0;
    end
    ep = '0;
  endfunction

  function automatic void model_pixel(input int x, input int y, input logic [N_CH-1:0] m);
    for (int c = 0; c < N_CH; c++)
      if (m[c] && mn[c] < (longint'(1) << CNT_W) - 1) begin
        msx[c] += x; msy[c] += y; mn[c] += 1;
      end
  endfunction

  function automatic void model_frame(input bit hold);
    for (int c = 0; c < N_CH; c++) begin
      if (mn[c] >= MIN_COUNT) begin
        ex[c] = (msx[c] / mn[c]) % (longint'(1) << H_W);
        ey[c] = (msy[c] / mn[c]) % (longint'(1) << V_W);
        ep[c] = 1'b1;
      end else begin
        ep[c] = 1'b0;
        if (!hold) begin ex[c] = 0; ey[c] = 0; end
      end
      msx[c] = 0; msy[c] = 0; mn[c] = 0;
    end
  endfunction

  function automatic logic [N_CH*H_W-1:0] exp_x();
    logic [N_CH*H_W-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c*H_W +: H_W] = H_W'(ex[c]);
    return v;
  endfunction

  function automatic logic [N_CH*V_W-1:0] exp_y();
    logic [N_CH*V_W-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c*V_W +: V_W] = V_W'(ey[c]);
    return v;
  endfunction

  task automatic pixel(input int x, input int y, input logic [N_CH-1:0] m);
    x_in = H_W'(x); y_in = V_W'(y); mask_in = m; valid_in = 1'b1;
    model_pixel(x, y, m);
    @(posedge clk); #1;
    valid_in = 1'b0; mask_in = '0;
  endtask

  task automatic block(input logic [N_CH-1:0] m, input int x0, input int y0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) pixel(x0 + j, y0 + i, m);
  endtask

  task automatic run_frame(input bit hold, input bit with_pix, input int px, input int py,
                           input logic [N_CH-1:0] pm, output int lat, output bit busy_seen,
                           output bit tail_ok);
    hold_in = hold; tabulate_in = 1'b1;
    model_frame(hold);
    if (with_pix) begin
      x_in = H_W'(px); y_in = V_W'(py); mask_in = pm; valid_in = 1'b1;
      model_pixel(px, py, pm);
    end
    @(posedge clk); #1;
    tabulate_in = 1'b0; valid_in = 1'b0; mask_in = '0;
    lat = -1; busy_seen = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) busy_seen = busy;
      if (valid_com) begin lat = k; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    tail_ok = !valid_com && !busy;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; x_in = '0; y_in = '0; valid_in = 1'b0; mask_in = '0;
    tabulate_in = 1'b0; hold_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({x_com, y_com, present, valid_com, busy, overrun} !== '0)
      $display("FAIL reset_state: got %0h expected 0", {x_com, y_com, present, valid_com, busy, overrun});
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_single_channel();
    int lat; bit bs, tail;
    block(2'b01, 100, 50);
    run_frame(1'b1, 1'b0, 0, 0, '0, lat, bs, tail);
    total++; if (lat !== LATENCY) $display("FAIL single_latency: got %0d expected %0d", lat, LATENCY); else passed++;
    total++; if (bs !== 1'b1) $display("FAIL single_busy: got %0b expected 1", bs); else passed++;
    total++;
    if (x_com[H_W-1:0] !== 11'd101 || y_com[V_W-1:0] !== 10'd51)
      $display("FAIL single_centroid: got (%0d,%0d) expected (101,51)", x_com[H_W-1:0], y_com[V_W-1:0]);
    else passed++;
    total++; if (present !== 2'b01) $display("FAIL single_present: got %b expected 01", present); else passed++;
    total++;
    if (x_com !== exp_x() || y_com !== exp_y())
      $display("FAIL single_model: got %0h/%0h expected %0h/%0h", x_com, y_com, exp_x(), exp_y());
    else passed++;
    total++; if (!tail) $display("FAIL single_pulse_width: got extra valid/busy expected single cycle"); else passed++;
  endtask

  task automatic test_two_channels();
    int lat; bit bs, tail;
    block(2'b01, 10, 20);
    block(2'b10, 300, 200);
    run_frame(1'b1, 1'b0, 0, 0, '0, lat, bs, tail);
    total++; if (lat !== LATENCY) $display("FAIL two_latency: got %0d expected %0d", lat, LATENCY); else passed++;
    total++;
    if (x_com !== {11'd301, 11'd11} || y_com !== {10'd201, 10'd21})
      $display("FAIL two_centroid: got %0h/%0h expected %0h/%0h", x_com, y_com, {11'd301, 11'd11}, {10'd201, 10'd21});
    else passed++;
    total++; if (present !== 2'b11) $display("FAIL two_present: got %b expected 11", present); else passed++;
  endtask

  task automatic test_below_min();
    int lat; bit bs, tail;
    block(2'b01, 100, 50);
    run_frame(1'b1, 1'b0, 0, 0, '0, lat, bs, tail);
    total++;
    if (x_com !== exp_x() || y_com !== exp_y() || present !== ep)
      $display("FAIL below_setup: got %0h/%0h/%b expected %0h/%0h/%b", x_com, y_com, present, exp_x(), exp_y(), ep);
    else passed++;
    for (int i = 0; i < 5; i++) pixel(20 + i, 30 + i, 2'b01);
    run_frame(1'b1, 1'b0, 0, 0, '0, lat, bs, tail);
    total++;
    if (x_com[H_W-1:0] !== 11'd101 || y_com[V_W-1:0] !== 10'd51 || present[0] !== 1'b0)
      $display("FAIL below_hold: got (%0d,%0d) p=%b expected (101,51) p=0", x_com[H_W-1:0], y_com[V_W-1:0], present[0]);
    else passed++;
    total++;
    if (x_com !== exp_x() || y_com !== exp_y() || present !== ep)
      $display("FAIL below_hold_model: got %0h/%0h/%b expected %0h/%0h/%b", x_com, y_com, present, exp_x(), exp_y(), ep);
    else passed++;
    for (int i = 0; i < 5; i++) pixel(20 + i, 30 + i, 2'b01);
    run_frame(1'b0, 1'b0, 0, 0, '0, lat, bs, tail);
    total++;
    if (x_com[H_W-1:0] !== 11'd0 || y_com[V_W-1:0] !== 10'd0 || present !== 2'b00)
      $display("FAIL below_zero: got (%0d,%0d) p=%b expected (0,0) p=00", x_com[H_W-1:0], y_com[V_W-1:0], present);
    else passed++;
  endtask

  task automatic test_boundary();
    int lat; bit bs, tail;
    block(2'b01, 200, 100);
    run_frame(1'b0, 1'b1, 7, 7, 2'b01, lat, bs, tail);
    total++;
    if (x_com[H_W-1:0] !== 11'd201 || y_com[V_W-1:0] !== 10'd101)
      $display("FAIL boundary_excluded: got (%0d,%0d) expected (201,101)", x_com[H_W-1:0], y_com[V_W-1:0]);
    else passed++;
    for (int i = 0; i < 15; i++) pixel(9, 9, 2'b01);
    run_frame(1'b0, 1'b0, 0, 0, '0, lat, bs, tail);
    total++;
    if (x_com[H_W-1:0] !== 11'd8 || y_com[V_W-1:0] !== 10'd8 || present[0] !== 1'b1)
      $display("FAIL boundary_included: got (%0d,%0d) p=%b expected (8,8) p=1", x_com[H_W-1:0], y_com[V_W-1:0], present[0]);
    else passed++;
    total++;
    if (x_com !== exp_x() || y_com !== exp_y() || present !== ep)
      $display("FAIL boundary_model: got %0h/%0h/%b expected %0h/%0h/%b", x_com, y_com, present, exp_x(), exp_y(), ep);
    else passed++;
  endtask

  task automatic test_overrun();
    int pulses; int first; int lat; bit bs, tail;
    pulses = 0; first = -1;
    block(2'b01, 600, 400);
    hold_in = 1'b1; tabulate_in = 1'b1;
    model_frame(1'b1);
    @(posedge clk); #1;
    tabulate_in = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k >= 5 && k < 21) begin
        x_in = H_W'(500 + (k - 5) % 4); y_in = V_W'(300 + (k - 5) / 4);
        mask_in = 2'b01; valid_in = 1'b1;
        model_pixel(500 + (k - 5) % 4, 300 + (k - 5) / 4, 2'b01);
      end
      tabulate_in = (k == 40);
      @(negedge clk);
      if (valid_com) begin pulses++; if (first < 0) first = k; end
      @(posedge clk); #1;
      valid_in = 1'b0; mask_in = '0; tabulate_in = 1'b0;
    end
    total++; if (pulses !== 1) $display("FAIL overrun_pulses: got %0d expected 1", pulses); else passed++;
    total++; if (first !== LATENCY) $display("FAIL overrun_latency: got %0d expected %0d", first, LATENCY); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL overrun_flag: got %0b expected 1", overrun); else passed++;
    total++;
    if (x_com !== exp_x() || y_com !== exp_y())
      $display("FAIL overrun_first: got %0h/%0h expected %0h/%0h", x_com, y_com, exp_x(), exp_y());
    else passed++;
    block(2'b01, 700, 100);
    run_frame(1'b1, 1'b0, 0, 0, '0, lat, bs, tail);
    total++;
    if (x_com[H_W-1:0] !== 11'd601 || y_com[V_W-1:0] !== 10'd201)
      $display("FAIL overrun_merge: got (%0d,%0d) expected (601,201)", x_com[H_W-1:0], y_com[V_W-1:0]);
    else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %0b expected 1", overrun); else passed++;
  endtask

  task automatic test_reset_mid_div();
    int pulses; int lat; bit bs, tail;
    pulses = 0;
    block(2'b01, 50, 60);
    block(2'b10, 70, 80);
    hold_in = 1'b1; tabulate_in = 1'b1;
    @(posedge clk); #1;
    tabulate_in = 1'b0;
    repeat (60) @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({x_com, y_com, present, valid_com, busy, overrun} !== '0)
      $display("FAIL midreset_outputs: got %0h expected 0", {x_com, y_com, present, valid_com, busy, overrun});
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (valid_com) pulses++;
      @(posedge clk); #1;
    end
    total++; if (pulses !== 0) $display("FAIL midreset_no_valid: got %0d expected 0", pulses); else passed++;
    block(2'b11, 1000, 900);
    run_frame(1'b0, 1'b0, 0, 0, '0, lat, bs, tail);
    total++;
    if (lat !== LATENCY || x_com !== exp_x() || y_com !== exp_y() || present !== ep)
      $display("FAIL midreset_clean: got lat=%0d %0h/%0h/%b expected lat=%0d %0h/%0h/%b",
               lat, x_com, y_com, present, LATENCY, exp_x(), exp_y(), ep);
    else passed++;
  endtask

  task automatic test_random();
    int n; int lat; bit bs, tail;
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(0, 40));
      for (int i = 0; i < n; i++) begin
        pixel(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), N_CH'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      run_frame(1'($urandom_range(0, 1)), 1'b0, 0, 0, '0, lat, bs, tail);
      total++; if (lat !== LATENCY) $display("FAIL random_latency[%0d]: got %0d expected %0d", f, lat, LATENCY); else passed++;
      total++;
      if (x_com !== exp_x() || y_com !== exp_y())
        $display("FAIL random_centroid[%0d]: got %0h/%0h expected %0h/%0h", f, x_com, y_com, exp_x(), exp_y());
      else passed++;
      total++; if (present !== ep) $display("FAIL random_present[%0d]: got %b expected %b", f, present, ep); else passed++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_channel();
    test_two_channels();
    test_below_min();
    test_boundary();
    test_overrun();
    test_reset_mid_div();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
